// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Radix-2 iterative MIPS MULT/MULTU/DIV/DIVU into HI/LO with a
//               start/busy/done handshake. Optional MULDIV_FAST_MUL_EN selects
//               a single-cycle combinational multiply.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_CNT_W = $clog2(ITERS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [63:0]          r_acc;
    logic [31:0]          r_operand;
    logic [31:0]          r_a_orig;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_done;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;

    logic [31:0]          w_a_mag;
    logic [31:0]          w_b_mag;
    logic [32:0]          w_mul_sum;
    logic [63:0]          w_mul_next;
    logic [32:0]          w_div_shift;
    logic [32:0]          w_div_diff;
    logic [63:0]          w_div_next;
    logic [63:0]          w_prod_fix;
    logic [31:0]          w_quo_fix;
    logic [31:0]          w_rem_fix;
    logic                 w_div_zero;

    assign w_a_mag = (op[0] && A[31]) ? -A : A;
    assign w_b_mag = (op[0] && B[31]) ? -B : B;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_operand} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Divide: acc = {remainder, dividend bits shifting out / quotient bits in}.
    assign w_div_shift = {r_acc[63:32], r_acc[31]};
    assign w_div_diff  = w_div_shift - {1'b0, r_operand};
    assign w_div_next  = w_div_diff[32] ? {w_div_shift[31:0], r_acc[30:0], 1'b0}
                                        : {w_div_diff[31:0],  r_acc[30:0], 1'b1};

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_q ? -r_acc[31:0] : r_acc[31:0];
    assign w_rem_fix  = r_neg_r ? -r_acc[63:32] : r_acc[63:32];
    assign w_div_zero = (r_operand == 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
`ifdef MULDIV_FAST_MUL_EN
                    w_next_state = op[1] ? S_RUN : S_FIX;
`else
                    w_next_state = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (r_cnt == c_CNT_W'(ITERS - 1)) begin
                    w_next_state = S_FIX;
                end
            end
            S_FIX:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_a_orig  <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wr_hi) r_hi <= wdata;
                    if (wr_lo) r_lo <= wdata;
                    if (start) begin
                        r_is_div  <= op[1];
                        r_neg_q   <= op[0] & (A[31] ^ B[31]);
                        r_neg_r   <= op[0] & A[31];
                        r_a_orig  <= A;
                        r_cnt     <= '0;
                        r_operand <= op[1] ? w_b_mag : w_a_mag;
`ifdef MULDIV_FAST_MUL_EN
                        r_acc     <= op[1] ? {32'd0, w_a_mag}
                                           : ({32'd0, w_a_mag} * {32'd0, w_b_mag});
`else
                        r_acc     <= {32'd0, (op[1] ? w_a_mag : w_b_mag)};
`endif
                    end
                end
                S_RUN: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (!r_is_div) begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end else if (w_div_zero) begin
                        // Divide by zero reports the untouched dividend.
                        r_hi <= r_a_orig;
                        r_lo <= 32'hFFFF_FFFF;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit with a
//               cycle-level behavioural model (honours MULDIV_FAST_MUL_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    muldiv_unit #(.ITERS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic [1:0] o);
        return (FAST && !o[1]) ? 2 : 34;
    endfunction

    // Architectural result {hi, lo} straight from the MIPS definitions.
    function automatic logic [63:0] model_result(input logic [1:0] o,
                                                 input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     p;
        p = '0;
        case (o)
            2'b00: p = {32'd0, a} * {32'd0, b};
            2'b01: begin
                sa = $signed(a);
                sb = $signed(b);
                p  = sa * sb;
            end
            2'b10: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    ua = a;
                    ub = b;
                    p  = {32'(ua % ub), 32'(ua / ub)};
                end
            end
            default: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    sa = $signed(a);
                    sb = $signed(b);
                    sq = sa / sb;
                    sr = sa % sb;
                    p  = {32'(sr), 32'(sq)};
                end
            end
        endcase
        return p;
    endfunction

    int          m_rem;
    logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
    logic        m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem    <= 0;
            m_hi     <= '0;
            m_lo     <= '0;
            m_done   <= 1'b0;
            m_res_hi <= '0;
            m_res_lo <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_rem == 0) begin
                if (wr_hi) m_hi <= wdata;
                if (wr_lo) m_lo <= wdata;
                if (start) begin
                    m_rem                <= lat_of(op) - 1;
                    {m_res_hi, m_res_lo} <= model_result(op, A, B);
                end
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_hi   <= m_res_hi;
                    m_lo   <= m_res_lo;
                    m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("model_busy", {31'd0, busy}, {31'd0, (m_rem != 0)});
            chk("model_done", {31'd0, done}, {31'd0, m_done});
            chk("model_hi", hi, m_hi);
            chk("model_lo", lo, m_lo);
        end
    end

    // Called on a falling edge; returns on the falling edge of the done cycle.
    // mode 0: plain, 1: start+wr_lo while busy (keep_lo = lo expected then),
    // 2: wr_lo together with start.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el,
                         input int mode, input logic [31:0] keep_lo);
        int lat_exp;
        int lat;
        lat_exp = lat_of(o);
        lat     = 0;
        op      = o;
        A       = a;
        B       = b;
        start   = 1'b1;
        if (mode == 2) begin
            wr_lo = 1'b1;
            wdata = 32'h77;
        end
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                wr_lo = 1'b0;
                A     = $urandom;
                B     = $urandom;
                op    = 2'($urandom);
                if (mode == 2) chk("wr_with_start", lo, 32'h77);
            end
            if (mode == 1 && i == 5) begin
                start = 1'b1;
                wr_lo = 1'b1;
                wdata = 32'h55;
                op    = 2'b00;
            end
            if (mode == 1 && i == 6) begin
                start = 1'b0;
                wr_lo = 1'b0;
            end
            if (mode == 1 && i == 7) chk("busy_ignore_lo", lo, keep_lo);
            chk("busy_cycle", {31'd0, busy}, {31'd0, (i < lat_exp)});
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(lat_exp));
        chk("hi", hi, eh);
        chk("lo", lo, el);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        A     = '0;
        B     = '0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        wr_hi = 1'b1;
        wdata = 32'h1234;
        @(negedge clk);
        wr_hi = 1'b0;
        chk("mthi", hi, 32'h1234);
        chk("mthi_lo_kept", lo, 32'd0);
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wdata = 32'hA5A5;
        @(negedge clk);
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        chk("mt_both_hi", hi, 32'hA5A5);
        chk("mt_both_lo", lo, 32'hA5A5);

        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
        do_op(2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
        do_op(2'b10, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 0, 0);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 0, 0);
        do_op(2'b11, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF, 0, 0);
        do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         0, 0);
        do_op(2'b10, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 0, 0);
        do_op(2'b10, 32'd1000,      32'd7,         32'd6,         32'd142,       1, 32'hFFFF_FFFF);
        do_op(2'b00, 32'd3,         32'd5,         32'd0,         32'd15,        2, 0);
        do_op(2'b10, 32'd15,        32'd4,         32'd3,         32'd3,         0, 0);
        do_op(2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0, 0);

        // Abort a divide mid-flight with reset.
        op    = 2'b10;
        A     = 32'd1000;
        B     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end

        do_op(2'b10, 32'd1000, 32'd7, 32'd6, 32'd142, 0, 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
